rot_cmd_sequencer: RTL
======================

Name: rot_cmd_sequencer

Overview:
- Upstream command stage for the 4-bit rotating shift register; drives that register's load, ena and data inputs.
- Accepts a command (data word + rotate count) over a valid/ready handshake, issues a one-cycle load, then issues exactly the requested number of rotate-enable cycles.
- A stall input can pause the rotate enables; a one-cycle done pulse marks completion.
- Sits between the command source and the shift register; one command in flight at a time.

Parameters:
DATA_W, 4, width of data word; must equal the downstream shift register width
CNT_W, 4, width of rotate count; max 2^CNT_W-1 rotates per command

Ports:
clk  input  1  clock, all state on rising edge
areset  input  1  reset, asynchronous, active-high
in_valid  input  1  command valid from source
in_ready  output  1  sequencer can accept a command
in_data  input  DATA_W  word to load into the shift register
in_rot  input  CNT_W  number of rotate-left steps to issue after the load
stall  input  1  suppresses ena while high; counts pause
load  output  1  load strobe to the shift register
ena  output  1  rotate enable to the shift register
data  output  DATA_W  load data to the shift register
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle completion pulse
rot_left  output  CNT_W  rotates still to issue

Behaviour:
- All outputs come directly from flops or decoded registered state; no combinational path from inputs to outputs except in_ready.
- in_ready = (state==IDLE) && !areset.
- Reset (async, any state, including mid-command):
  - state=IDLE.
  - load=0, ena=0, done=0, busy=0, data=0, rot_left=0.
  - In-flight command is discarded; no done pulse.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - On clock edge with in_valid && in_ready: capture in_data into data and in_rot into rot_left; go to LOAD.
  - in_valid without acceptance has no effect.
- LOAD: load=1 for exactly one cycle, data holds the captured word.
  - Next state SHIFT if rot_left!=0, else DONE.
- SHIFT: ena = !stall (combinational gate of registered state with stall is not allowed).
  - Implement stall as registered: ena in cycle k reflects stall sampled at edge k-1.
  - ena is 1 on the first SHIFT cycle regardless of stall.
  - Each cycle with ena=1: rot_left decrements by 1 at the closing edge.
  - Transition to DONE at the edge where ena=1 and rot_left==1.
- DONE: done=1 for one cycle; rot_left=0; next state IDLE.
- load and ena are never high in the same cycle; ena never high outside SHIFT.
- Exact ena-high count per command equals captured in_rot, including in_rot = 2^CNT_W-1.
- No wrap of rot_left below 0.
- data holds its value from capture until the next capture; it is not cleared at DONE.
- busy = 1 in LOAD, SHIFT and DONE.
- Latency with no stall, command accepted at edge N:
  - load high in cycle N+1.
  - ena high in cycles N+2 .. N+1+R.
  - done high in cycle N+2+R (N+2 if R=0).
  - in_ready high again in cycle N+3+R.
- Back-to-back commands: minimum spacing R+3 cycles between acceptances.

Test Plan:
- Reset then in_valid=1, in_data=4'b1001, in_rot=3, stall=0 -> load=1 with data=1001 one cycle; ena=1 exactly 3 cycles; done pulse next; downstream q=4'b1100.
- in_rot=0, in_data=4'hA -> load one cycle, done the following cycle; ena never asserted; in_ready returns after 3 cycles.
- in_rot=4, stall high for 2 cycles after the first ena -> total ena count still 4; rot_left holds during the stall; done arrives 2 cycles later than the unstalled case.
- in_rot=15 -> exactly 15 ena cycles; rot_left steps 15→0 without wrap; done once.
- areset pulsed mid-SHIFT with rot_left=5 -> all outputs 0 immediately; no done; next command is accepted normally.
- in_valid held high continuously -> one command accepted per completion; in_ready low while busy; each command's data and rotate count are honoured independently.

Source files
------------

// File: rtl/rot_cmd_sequencer.sv
//-----------------------------------------------------------------------------
// rot_cmd_sequencer
//
// Command stage in front of the rotating shift register. It accepts one
// command (data word + rotate count) over a valid/ready handshake. It then
// issues a single-cycle load of the word, followed by exactly the requested
// number of rotate-enable cycles. A stall input can pause those enables.
// A one-cycle done pulse closes each command. Only one command is in flight
// at a time.
//
// Ports
//   clk       in   clock; all state changes on the rising edge
//   areset    in   asynchronous, active-high reset
//   in_valid  in   command valid from the source
//   in_ready  out  sequencer can accept a command (idle and not in reset)
//   in_data   in   word to load into the shift register
//   in_rot    in   number of rotate-left steps to issue after the load
//   stall     in   pauses the rotate enables (registered, one cycle delay)
//   load      out  load strobe to the shift register
//   ena       out  rotate enable to the shift register
//   data      out  load data; held from capture until the next capture
//   busy      out  command in progress
//   done      out  one-cycle completion pulse
//   rot_left  out  rotates still to issue
//-----------------------------------------------------------------------------
module rot_cmd_sequencer #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  in_rot,
    input  logic              stall,
    output logic              load,
    output logic              ena,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  rot_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  ROT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  ROT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] data_s;
    logic [CNT_W-1:0]  rot_left_r;
    logic [CNT_W-1:0]  rot_left_s;
    logic              ena_r;
    logic              ena_s;
    logic              load_r;
    logic              done_r;
    logic              busy_r;

    // The ready path is the only combinational route to an output. It is
    // forced low while reset is asserted.
    assign in_ready = (state_r == IDLE) && !areset;

    // Next-state, capture and rotate-count logic.
    // ena_s is the enable for the *next* cycle. Registering it means the
    // stall sampled at an edge decides ena in the following cycle. The
    // first SHIFT cycle is therefore always enabled.
    always_comb begin
        state_s    = state_r;
        data_s     = data_r;
        rot_left_s = rot_left_r;
        ena_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s    = LOAD;
                    data_s     = in_data;
                    rot_left_s = in_rot;
                end else begin
                    state_s    = IDLE;
                end
            end
            LOAD: begin
                if (rot_left_r != ROT_ZERO) begin
                    state_s = SHIFT;
                    ena_s   = 1'b1;
                end else begin
                    state_s = DONE;
                end
            end
            SHIFT: begin
                if (rot_left_r == ROT_ZERO) begin
                    // Defensive exit: never decrement through zero.
                    state_s = DONE;
                end else if (ena_r) begin
                    if (rot_left_r == ROT_ONE) begin
                        // The last rotate is being issued this cycle.
                        state_s    = DONE;
                        rot_left_s = ROT_ZERO;
                    end else begin
                        rot_left_s = rot_left_r - ROT_ONE;
                        ena_s      = !stall;
                    end
                end else begin
                    // Stalled cycle: count holds, re-evaluate stall.
                    ena_s = !stall;
                end
            end
            DONE: begin
                state_s    = IDLE;
                rot_left_s = ROT_ZERO;
            end
            default: begin
                state_s    = IDLE;
                rot_left_s = ROT_ZERO;
            end
        endcase
    end

    // State and output registers. Every output except in_ready is a flop,
    // loaded from the next-state decode.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_r    <= IDLE;
            data_r     <= DATA_ZERO;
            rot_left_r <= ROT_ZERO;
            ena_r      <= 1'b0;
            load_r     <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            data_r     <= data_s;
            rot_left_r <= rot_left_s;
            ena_r      <= ena_s;
            load_r     <= (state_s == LOAD);
            done_r     <= (state_s == DONE);
            busy_r     <= (state_s != IDLE);
        end
    end

    assign load     = load_r;
    assign ena      = ena_r;
    assign data     = data_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign rot_left = rot_left_r;

endmodule
